// File: rtl/rr_encoder_pkg.sv
// rr_encoder shared types and sizes.
// Imported by the encoder, its interface and the sub-module.
package encoder_pkg;

  localparam int NUM_REQ = 32;
  localparam int ADDR_W  = 5;

  typedef logic [NUM_REQ-1:0] req_vec_t;
  typedef logic [ADDR_W-1:0]  addr_t;

endpackage

// File: rtl/rr_encoder_if.sv
// Output handshake of the round-robin encoder.
// master drives the selection, slave consumes it.
interface rr_encoder_if;
  import encoder_pkg::*;

  logic     out_valid;
  logic     out_ready;
  addr_t    out_addr;
  req_vec_t out_grant;

  modport master (
    output out_valid,
    output out_addr,
    output out_grant,
    input  out_ready
  );

  modport slave (
    input  out_valid,
    input  out_addr,
    input  out_grant,
    output out_ready
  );

endinterface

// File: rtl/rr_encoder_priority_enc32.sv
// Fixed-priority 32-to-5 encoder.
// Lowest set index wins; any flags a non-zero input.
module priority_enc32
  import encoder_pkg::*;
(
  input  req_vec_t req,
  output logic     any,
  output addr_t    idx
);

  // scan downward so the lowest set bit is written last
  always_comb begin
    any = |req;
    idx = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (req[i]) idx = addr_t'(i);
    end
  end

endmodule

// File: rtl/rr_encoder.sv
// Round-robin 32-to-5 request encoder.
// Registered index/grant behind a valid/ready handshake.
module rr_encoder
  import encoder_pkg::*;
(
  input  logic         clk,
  input  logic         reset_n,
  input  logic         clear,
  input  req_vec_t     req,
  rr_encoder_if.master bus
);

  logic     vld;
  addr_t    addr;
  addr_t    ptr;

  req_vec_t mask;
  req_vec_t req_m;
  logic     any_m;
  logic     any_u;
  addr_t    idx_m;
  addr_t    idx_u;
  addr_t    sel;
  logic     load;
  logic     hs;

  assign mask  = {NUM_REQ{1'b1}} << ptr;
  assign req_m = req & mask;

  priority_enc32 u_enc_m (
    .req (req_m),
    .any (any_m),
    .idx (idx_m)
  );

  priority_enc32 u_enc_u (
    .req (req),
    .any (any_u),
    .idx (idx_u)
  );

  // wrap to the unmasked search when nothing at or above ptr
  assign sel  = any_m ? idx_m : idx_u;
  assign hs   = vld & bus.out_ready;
  assign load = ~clear & (~vld | bus.out_ready) & any_u;

  // output register and priority pointer; clear beats load
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      vld  <= 1'b0;
      addr <= '0;
      ptr  <= '0;
    end else if (clear) begin
      vld  <= 1'b0;
      ptr  <= '0;
    end else if (load) begin
      vld  <= 1'b1;
      addr <= sel;
      ptr  <= sel + addr_t'(1);
    end else if (hs) begin
      vld  <= 1'b0;
    end
  end

  assign bus.out_valid = vld;
  assign bus.out_addr  = addr;
  assign bus.out_grant = vld ? (req_vec_t'(1) << addr) : '0;

endmodule
